// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, centisecond prescaler and mm:ss.cc counters.
// Define STOPWATCH_LAP_EN to build the lap (display freeze) feature; without it lap is ignored.
module stopwatch_ctrl #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 100
) (
   input  logic       clk,
   input  logic       aclr,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [6:0] centis,
   output logic [5:0] secs,
   output logic [5:0] mins,
   output logic       running,
   output logic       overflow
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t           state;
   logic [PRE_W-1:0] pre_cnt;
   logic [6:0]       cs_cnt;
   logic [5:0]       sec_cnt;
   logic [5:0]       min_cnt;

   logic tick;
   logic zero_req;
   logic cs_last;
   logic sec_last;
   logic min_last;

   assign tick     = (state == RUN) && (pre_cnt == PRE_LAST);
   assign zero_req = (state == IDLE) || ((state == PAUSE) && clear);
   assign cs_last  = (cs_cnt == 7'd99);
   assign sec_last = (sec_cnt == 6'd59);
   assign min_last = (min_cnt == 6'd59);

   // Clear outranks start_stop outside RUN; clear is ignored while running.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state   <= IDLE;
         running <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!clear && start_stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (start_stop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
            end
            PAUSE: begin
               if (clear) begin
                  state   <= IDLE;
                  running <= 1'b0;
               end else if (start_stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   // The prescaler holds its value in PAUSE so a resume finishes the partial tick.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         pre_cnt  <= '0;
         cs_cnt   <= '0;
         sec_cnt  <= '0;
         min_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (zero_req) begin
            pre_cnt <= '0;
            cs_cnt  <= '0;
            sec_cnt <= '0;
            min_cnt <= '0;
         end else if (state == RUN) begin
            if (tick) begin
               pre_cnt <= '0;
            end else begin
               pre_cnt <= pre_cnt + 1'b1;
            end
            if (tick) begin
               if (cs_last) begin
                  cs_cnt <= '0;
                  if (sec_last) begin
                     sec_cnt <= '0;
                     if (min_last) begin
                        min_cnt  <= '0;
                        overflow <= 1'b1;
                     end else begin
                        min_cnt <= min_cnt + 6'd1;
                     end
                  end else begin
                     sec_cnt <= sec_cnt + 6'd1;
                  end
               end else begin
                  cs_cnt <= cs_cnt + 7'd1;
               end
            end
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic       frozen;
   logic [6:0] lap_cs;
   logic [5:0] lap_sec;
   logic [5:0] lap_min;

   // Leaving RUN always drops the freeze, even if a lap pulse arrives on the same edge.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         frozen  <= 1'b0;
         lap_cs  <= '0;
         lap_sec <= '0;
         lap_min <= '0;
      end else if ((state != RUN) || start_stop) begin
         frozen <= 1'b0;
      end else if (lap) begin
         frozen <= !frozen;
         if (!frozen) begin
            lap_cs  <= cs_cnt;
            lap_sec <= sec_cnt;
            lap_min <= min_cnt;
         end
      end
   end

   assign centis = frozen ? lap_cs  : cs_cnt;
   assign secs   = frozen ? lap_sec : sec_cnt;
   assign mins   = frozen ? lap_min : min_cnt;
`else
   logic unused_lap;

   assign unused_lap = lap;
   assign centis     = cs_cnt;
   assign secs       = sec_cnt;
   assign mins       = min_cnt;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at 10 clocks per tick; inputs change and outputs are sampled on negedges.
// Lap checks are built only when STOPWATCH_LAP_EN is defined, otherwise lap must be ignored.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       aclr;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [6:0] centis;
   logic [5:0] secs;
   logic [5:0] mins;
   logic       running;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   stopwatch_ctrl #(
      .CLK_HZ (10),
      .TICK_HZ(1)
   ) dut (
      .clk       (clk),
      .aclr      (aclr),
      .start_stop(start_stop),
      .clear     (clear),
      .lap       (lap),
      .centis    (centis),
      .secs      (secs),
      .mins      (mins),
      .running   (running),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one-cycle command pulses; always called right after a negedge.
   task automatic pulse(input logic ss, input logic clr, input logic lp);
      start_stop = ss;
      clear      = clr;
      lap        = lp;
      @(negedge clk);
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
   endtask

   task automatic do_reset();
      aclr = 1'b0;
      wait_clocks(2);
      aclr = 1'b1;
      wait_clocks(1);
   endtask

   task automatic test_reset();
      aclr = 1'b0;
      wait_clocks(1);
      total++;
      if ({mins, secs, centis, running, overflow} !== 21'd0) begin
         bad++;
         $display("[TB] FAIL reset_hold: got %h expected 0", {mins, secs, centis, running, overflow});
      end
      aclr = 1'b1;
      wait_clocks(15);
      total++;
      if ({mins, secs, centis, running, overflow} !== 21'd0) begin
         bad++;
         $display("[TB] FAIL idle_no_count: got %h expected 0", {mins, secs, centis, running, overflow});
      end
   endtask

   task automatic test_run();
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(35);
      total++;
      if (centis !== 7'd3 || secs !== 6'd0 || running !== 1'b1) begin
         bad++;
         $display("[TB] FAIL run_35: got centis=%0d secs=%0d running=%0d expected 3 0 1", centis, secs, running);
      end
`ifndef STOPWATCH_LAP_EN
      pulse(1'b0, 1'b0, 1'b1);
      wait_clocks(4);
      total++;
      if (centis !== 7'd4) begin
         bad++;
         $display("[TB] FAIL lap_ignored: got %0d expected 4", centis);
      end
`endif
   endtask

   task automatic test_pause_resume();
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(24);
      pulse(1'b1, 1'b0, 1'b0);
      total++;
      if (centis !== 7'd2 || running !== 1'b0) begin
         bad++;
         $display("[TB] FAIL pause_enter: got centis=%0d running=%0d expected 2 0", centis, running);
      end
      wait_clocks(20);
      total++;
      if (centis !== 7'd2) begin
         bad++;
         $display("[TB] FAIL pause_hold: got %0d expected 2", centis);
      end
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(4);
      total++;
      if (centis !== 7'd2 || running !== 1'b1) begin
         bad++;
         $display("[TB] FAIL resume_partial: got centis=%0d running=%0d expected 2 1", centis, running);
      end
      wait_clocks(1);
      total++;
      if (centis !== 7'd3) begin
         bad++;
         $display("[TB] FAIL resume_tick: got %0d expected 3", centis);
      end
   endtask

   task automatic test_stop_on_tick();
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(9);
      pulse(1'b1, 1'b0, 1'b0);
      total++;
      if (centis !== 7'd1 || running !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stop_on_tick: got centis=%0d running=%0d expected 1 0", centis, running);
      end
      wait_clocks(15);
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(9);
      total++;
      if (centis !== 7'd1) begin
         bad++;
         $display("[TB] FAIL resume_full_pre: got %0d expected 1", centis);
      end
      wait_clocks(1);
      total++;
      if (centis !== 7'd2) begin
         bad++;
         $display("[TB] FAIL resume_full_tick: got %0d expected 2", centis);
      end
   endtask

   task automatic test_overflow();
      int ovf_seen;
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      force dut.cs_cnt  = 7'd99;
      force dut.sec_cnt = 6'd59;
      force dut.min_cnt = 6'd59;
      #1;
      release dut.cs_cnt;
      release dut.sec_cnt;
      release dut.min_cnt;
      wait_clocks(9);
      total++;
      if ({mins, secs, centis} !== {6'd59, 6'd59, 7'd99} || overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL preload: got %0d:%0d.%0d ovf=%0d expected 59:59.99 ovf=0", mins, secs, centis, overflow);
      end
      wait_clocks(1);
      total++;
      if ({mins, secs, centis} !== 19'd0 || overflow !== 1'b1 || running !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wrap: got %0d:%0d.%0d ovf=%0d run=%0d expected 0:0.0 ovf=1 run=1", mins, secs, centis, overflow, running);
      end
      ovf_seen = 1;
      for (int i = 0; i < 12; i++) begin
         wait_clocks(1);
         if (overflow === 1'b1) ovf_seen++;
      end
      total++;
      if (ovf_seen !== 1 || centis !== 7'd1) begin
         bad++;
         $display("[TB] FAIL ovf_single: got pulses=%0d centis=%0d expected 1 1", ovf_seen, centis);
      end
   endtask

   task automatic test_clear();
      do_reset();
      pulse(1'b0, 1'b1, 1'b0);
      total++;
      if ({mins, secs, centis, running} !== 20'd0) begin
         bad++;
         $display("[TB] FAIL idle_clear: got %h expected 0", {mins, secs, centis, running});
      end
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(24);
      pulse(1'b0, 1'b1, 1'b0);
      total++;
      if (centis !== 7'd2 || running !== 1'b1) begin
         bad++;
         $display("[TB] FAIL run_clear_ignored: got centis=%0d running=%0d expected 2 1", centis, running);
      end
      wait_clocks(5);
      total++;
      if (centis !== 7'd3) begin
         bad++;
         $display("[TB] FAIL run_clear_keeps_pre: got %0d expected 3", centis);
      end
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b1, 1'b0);
      total++;
      if ({mins, secs, centis, running, overflow} !== 21'd0) begin
         bad++;
         $display("[TB] FAIL pause_clear_priority: got %h expected 0", {mins, secs, centis, running, overflow});
      end
      wait_clocks(15);
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(9);
      total++;
      if (centis !== 7'd0 || running !== 1'b1) begin
         bad++;
         $display("[TB] FAIL restart_pre_zero: got centis=%0d running=%0d expected 0 1", centis, running);
      end
      wait_clocks(1);
      total++;
      if (centis !== 7'd1) begin
         bad++;
         $display("[TB] FAIL restart_tick: got %0d expected 1", centis);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(25);
      #2 aclr = 1'b0;
      #1;
      total++;
      if ({mins, secs, centis, running, overflow} !== 21'd0) begin
         bad++;
         $display("[TB] FAIL async_reset_now: got %h expected 0", {mins, secs, centis, running, overflow});
      end
      @(negedge clk);
      aclr = 1'b1;
      wait_clocks(20);
      total++;
      if ({mins, secs, centis, running} !== 20'd0) begin
         bad++;
         $display("[TB] FAIL post_reset_idle: got %h expected 0", {mins, secs, centis, running});
      end
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(10);
      total++;
      if (centis !== 7'd1 || running !== 1'b1) begin
         bad++;
         $display("[TB] FAIL post_reset_start: got centis=%0d running=%0d expected 1 1", centis, running);
      end
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      wait_clocks(20);
      pulse(1'b0, 1'b0, 1'b1);
      total++;
      if (centis !== 7'd2) begin
         bad++;
         $display("[TB] FAIL lap_capture: got %0d expected 2", centis);
      end
      wait_clocks(30);
      total++;
      if (centis !== 7'd2) begin
         bad++;
         $display("[TB] FAIL lap_frozen: got %0d expected 2", centis);
      end
      pulse(1'b0, 1'b0, 1'b1);
      total++;
      if (centis !== 7'd5) begin
         bad++;
         $display("[TB] FAIL lap_release: got %0d expected 5", centis);
      end
      pulse(1'b0, 1'b0, 1'b1);
      wait_clocks(10);
      total++;
      if (centis !== 7'd5) begin
         bad++;
         $display("[TB] FAIL lap_refreeze: got %0d expected 5", centis);
      end
      pulse(1'b1, 1'b0, 1'b0);
      total++;
      if (centis !== 7'd6 || running !== 1'b0) begin
         bad++;
         $display("[TB] FAIL lap_pause_release: got centis=%0d running=%0d expected 6 0", centis, running);
      end
   endtask
`endif

   initial begin
      aclr       = 1'b0;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      test_reset();
      test_run();
      test_pause_resume();
      test_stop_on_tick();
      test_overflow();
      test_clear();
      test_async_reset();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
